// File: rtl/fetch_pkg.sv
// Shared fetch-stage types: queue entry layout, queue sizing helpers and the
// RV32I major opcodes that decode also keys on.
package fetch_pkg;

  localparam int FQ_PC_W = 32;

  // PC is stored at full width so the entry type is independent of IM size
  typedef struct packed {
    logic [FQ_PC_W-1:0] pc;
    logic [31:0]        instr;
  } fq_entry_t;

  function automatic int fq_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int fq_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries; flush/reset clear occupancy and win over
// push/pop, head reads as zero while empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int FQ_DEPTH = 4,
  localparam int CW       = fq_cnt_w(FQ_DEPTH),
  localparam int PW       = fq_ptr_w(FQ_DEPTH)
) (
  input  logic          clk_100MHz,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  fq_entry_t     push_data,
  input  logic          pop,
  output fq_entry_t     head,
  output logic [CW-1:0] count
);

  fq_entry_t     mem_q [FQ_DEPTH];
  fq_entry_t     mem_d [FQ_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (reset || flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_100MHz) begin
    mem_q    <= mem_d;
    wr_ptr_q <= wr_ptr_d;
    rd_ptr_q <= rd_ptr_d;
    cnt_q    <= cnt_d;
  end

  assign head  = (cnt_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count = cnt_q;

endmodule

// File: rtl/instruction_memory.sv
// Word-organised instruction store, byte-addressed ports, one write port and
// two synchronous read ports with one cycle of latency.
module instruction_memory #(
  parameter  int IM_DEPTH = 256,
  localparam int AW       = $clog2(IM_DEPTH * 4)
) (
  input  logic          clk_100MHz,
  input  logic [AW-1:0] writeAddr,
  input  logic [31:0]   writeData,
  input  logic          writeEn,
  input  logic          readEn_1,
  input  logic [AW-1:0] readAddr_1,
  output logic [31:0]   readData_1,
  input  logic          readEn_2,
  input  logic [AW-1:0] readAddr_2,
  output logic [31:0]   readData_2
);

  logic [31:0] mem_q [IM_DEPTH];

  always_ff @(posedge clk_100MHz) begin
    if (writeEn) mem_q[writeAddr[AW-1:2]] <= writeData;
    if (readEn_1) readData_1 <= mem_q[readAddr_1[AW-1:2]];
    if (readEn_2) readData_2 <= mem_q[readAddr_2[AW-1:2]];
  end

endmodule

// File: rtl/fetch_queue_unit.sv
// Instruction fetch stage: issues IM reads only when a queue slot is reserved
// for the response, hands instructions to decode over valid/ready.
module fetch_queue_unit
  import fetch_pkg::*;
#(
  parameter  int IM_DEPTH = 256,
  parameter  int FQ_DEPTH = 4,
  parameter  int RESET_PC = 0,
  localparam int AW       = $clog2(IM_DEPTH * 4)
) (
  input  logic                          clk_100MHz,
  input  logic                          reset,
  input  logic                          mem_init,
  input  logic [AW-1:0]                 writeAddr_IM,
  input  logic [31:0]                   writeData_IM,
  input  logic                          writeEn_IM,
  input  logic                          redirect_valid,
  input  logic [AW-1:0]                 redirect_pc,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [31:0]                   out_instr,
  output logic [AW-1:0]                 out_pc,
  output logic [$clog2(FQ_DEPTH+1)-1:0] fq_count
);

  localparam int            CW      = fq_cnt_w(FQ_DEPTH);
  localparam logic [AW-1:0] RST_PC  = AW'(RESET_PC);
  localparam logic [AW-1:0] PC_LAST = AW'(IM_DEPTH * 4 - 4);

  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] tag_pc_q, tag_pc_d;
  logic          inflight_q, inflight_d;

  logic          hold, pop, push, issue;
  logic [CW:0]   pending;
  logic [CW-1:0] count;
  logic [31:0]   im_rdata, im_rdata_2;
  fq_entry_t     push_data, head;

  assign hold = reset | mem_init;
  assign pop  = out_valid & out_ready;
  assign push = inflight_q & ~hold & ~redirect_valid;

  // Slots already spoken for after this cycle; a new read needs one more
  assign pending = {1'b0, count} + (CW+1)'(inflight_q) - (CW+1)'(pop);
  assign issue   = ~hold & ~redirect_valid & (pending < (CW+1)'(FQ_DEPTH));

  always_comb begin
    pc_d       = pc_q;
    tag_pc_d   = tag_pc_q;
    inflight_d = 1'b0;
    if (hold) begin
      pc_d     = RST_PC;
      tag_pc_d = '0;
    end else if (redirect_valid) begin
      pc_d = {redirect_pc[AW-1:2], 2'b00};
    end else if (issue) begin
      pc_d       = (pc_q == PC_LAST) ? '0 : pc_q + AW'(4);
      tag_pc_d   = pc_q;
      inflight_d = 1'b1;
    end
  end

  always_ff @(posedge clk_100MHz) begin
    pc_q       <= pc_d;
    tag_pc_q   <= tag_pc_d;
    inflight_q <= inflight_d;
  end

  instruction_memory #(.IM_DEPTH(IM_DEPTH)) u_im (
    .clk_100MHz (clk_100MHz),
    .writeAddr  (writeAddr_IM),
    .writeData  (writeData_IM),
    .writeEn    (writeEn_IM),
    .readEn_1   (issue),
    .readAddr_1 (pc_q),
    .readData_1 (im_rdata),
    .readEn_2   (1'b0),
    .readAddr_2 ('0),
    .readData_2 (im_rdata_2)
  );

  assign push_data = '{pc: FQ_PC_W'(tag_pc_q), instr: im_rdata};

  fetch_fifo #(.FQ_DEPTH(FQ_DEPTH)) u_fifo (
    .clk_100MHz (clk_100MHz),
    .reset      (hold),
    .flush      (redirect_valid),
    .push       (push),
    .push_data  (push_data),
    .pop        (pop),
    .head       (head),
    .count      (count)
  );

  assign out_valid = (count != '0);
  assign out_instr = head.instr;
  assign out_pc    = head.pc[AW-1:0];
  assign fq_count  = count;

endmodule
